vga_scene_sequencer: RTL and testbench

//  Frame-rate scene controller for the VGA logo pipeline. It detects frame starts from vpos and

---
 rtl/vga_scene_sequencer.sv | 156 +++++++++++++++
 tb/tb_vga_scene_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scene_sequencer.sv
// Frame-rate scene controller: steps a FADE_IN/HOLD/SCROLL/FADE_OUT animation once per frame
// and shadow-registers the background/logo configuration. Define SCENE_PAUSE_EN for pause/step.
module vga_scene_sequencer #(
  parameter int FADE_STEP     = 8,
  parameter int HOLD_FRAMES   = 120,
  parameter int SCROLL_FRAMES = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  vpos,
  input  logic [1:0]  speed,
  input  logic        dir,
  input  logic        pause,
  input  logic        step,
  output logic [17:0] bg_inc,
  output logic [2:0]  bg_step,
  output logic [17:0] logo_rgb18,
  output logic        logo_en,
  output logic [1:0]  phase,
  output logic [10:0] frame_cnt,
  output logic        cfg_update
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    SCROLL   = 2'd2,
    FADE_OUT = 2'd3
  } phase_t;

  localparam logic [6:0]  STEP7       = 7'(FADE_STEP);
  localparam logic [7:0]  HOLD_LOAD   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  SCROLL_LOAD = 8'(SCROLL_FRAMES - 1);
  localparam logic [17:0] BG_INC_RST  = 18'h01FC1;

  phase_t      state, state_next;
  logic [5:0]  lvl, lvl_next;
  logic [7:0]  timer, timer_next;
  logic [9:0]  vpos_q;
  logic [6:0]  lvl_up, lvl_dn;
  logic        frame_tick;
  logic        advance;

  assign frame_tick = (vpos == 10'd0) && (vpos_q != 10'd0);

`ifdef SCENE_PAUSE_EN
  logic step_q, step_rise, armed;

  assign step_rise = step & ~step_q;
  // A step edge coinciding with the tick counts for that tick; any tick consumes the one-shot.
  assign advance   = frame_tick & (~pause | armed | step_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      step_q <= step;
      if (frame_tick)     armed <= 1'b0;
      else if (step_rise) armed <= 1'b1;
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = pause ^ step;
  assign advance     = frame_tick;
`endif

  // 7-bit intermediates: bit 6 of lvl_dn flags underflow, lvl_up >= 63 flags saturation.
  assign lvl_up = {1'b0, lvl} + STEP7;
  assign lvl_dn = {1'b0, lvl} - STEP7;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    lvl_next   = lvl;
    timer_next = timer;
    unique case (state)
      FADE_IN: begin
        if (lvl_up >= 7'd63) begin
          lvl_next   = 6'd63;
          state_next = HOLD;
          timer_next = HOLD_LOAD;
        end else begin
          lvl_next = lvl_up[5:0];
        end
      end
      HOLD: begin
        if (timer == 8'd0) begin
          state_next = SCROLL;
          timer_next = SCROLL_LOAD;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      SCROLL: begin
        if (timer == 8'd0) begin
          state_next = FADE_OUT;
          timer_next = 8'd0;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      FADE_OUT: begin
        if (lvl_dn[6] || lvl_dn == 7'd0) begin
          lvl_next   = 6'd0;
          state_next = FADE_IN;
        end else begin
          lvl_next = lvl_dn[5:0];
        end
      end
      default: state_next = FADE_IN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FADE_IN;
      lvl       <= 6'd0;
      timer     <= 8'd0;
      vpos_q    <= 10'd0;
      frame_cnt <= 11'd0;
    end else begin
      vpos_q <= vpos;
      if (frame_tick) frame_cnt <= frame_cnt + 11'd1;
      if (advance) begin
        state <= state_next;
        lvl   <= lvl_next;
        timer <= timer_next;
      end
    end
  end

  // Shadow registers: loaded only on an advancing tick, so consumers never see a mid-frame change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_inc     <= BG_INC_RST;
      bg_step    <= 3'd0;
      logo_rgb18 <= 18'd0;
      logo_en    <= 1'b0;
      phase      <= FADE_IN;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= advance;
      if (advance) begin
        bg_inc     <= {5'b0, ~dir, 6'h3F, 6'h01};
        bg_step    <= (state_next == SCROLL) ? ({1'b0, speed} + 3'd1) : 3'd0;
        logo_rgb18 <= {3{lvl_next}};
        logo_en    <= (lvl_next != 6'd0);
        phase      <= state_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Directed self-checking bench for vga_scene_sequencer (HOLD_FRAMES=4, SCROLL_FRAMES=2, FADE_STEP=8).
module tb_vga_scene_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vpos;
  logic [1:0]  speed;
  logic        dir;
  logic        pause;
  logic        step;
  logic [17:0] bg_inc;
  logic [2:0]  bg_step;
  logic [17:0] logo_rgb18;
  logic        logo_en;
  logic [1:0]  phase;
  logic [10:0] frame_cnt;
  logic        cfg_update;

  int checks   = 0;
  int failures = 0;
  int cfg_cnt  = 0;
  int exp_fc   = 0;

  vga_scene_sequencer #(
    .FADE_STEP    (8),
    .HOLD_FRAMES  (4),
    .SCROLL_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vpos      (vpos),
    .speed     (speed),
    .dir       (dir),
    .pause     (pause),
    .step      (step),
    .bg_inc    (bg_inc),
    .bg_step   (bg_step),
    .logo_rgb18(logo_rgb18),
    .logo_en   (logo_en),
    .phase     (phase),
    .frame_cnt (frame_cnt),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  task automatic clk1(input logic [9:0] v);
    vpos = v;
    @(posedge clk);
    #1;
    if (cfg_update) cfg_cnt++;
  endtask

  task automatic run_frame(input int len);
    for (int v = 0; v < len; v++) clk1(10'(v));
  endtask

  // Frame whose tick lands while paused, with three step pulses later in the same frame.
  task automatic step_frame();
    clk1(10'd0);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; clk1(10'(2 * p + 1));
      step = 1'b0; clk1(10'(2 * p + 2));
    end
    clk1(10'd7);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (bg_inc !== 18'h01FC1 || bg_step !== 3'd0 || logo_rgb18 !== 18'd0 || logo_en !== 1'b0 ||
        phase !== 2'd0 || frame_cnt !== 11'd0 || cfg_update !== 1'b0) begin
      failures++;
      $display("FAIL %s: got bg_inc=%h bg_step=%0d logo=%h en=%b phase=%0d fc=%0d cfg=%b expected 01fc1/0/0/0/0/0/0",
               tag, bg_inc, bg_step, logo_rgb18, logo_en, phase, frame_cnt, cfg_update);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vpos = 10'd0; speed = 2'd2; dir = 1'b0; pause = 1'b0; step = 1'b0;
    #12;
    check_reset_vals("reset_values");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    cfg_cnt = 0;
    repeat (20) clk1(10'd0);
    run_frame(8);
    check_reset_vals("idle_after_reset");
    checks++;
    if (cfg_cnt !== 0) begin
      failures++;
      $display("FAIL idle_cfg_pulses: got %0d expected 0", cfg_cnt);
    end
  endtask

  task automatic test_fade_in();
    logic [5:0] exp_lvl;
    for (int k = 1; k <= 8; k++) begin
      cfg_cnt = 0;
      run_frame(525);
      exp_fc++;
      exp_lvl = (k * 8 > 63) ? 6'd63 : 6'(k * 8);
      checks++;
      if (logo_rgb18 !== {3{exp_lvl}} || logo_en !== 1'b1 || phase !== ((k == 8) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL fade_in_%0d: got logo=%h en=%b phase=%0d expected logo=%h en=1 phase=%0d",
                 k, logo_rgb18, logo_en, phase, {3{exp_lvl}}, (k == 8) ? 1 : 0);
      end
      checks++;
      if (cfg_cnt !== 1) begin
        failures++;
        $display("FAIL fade_in_cfg_%0d: got %0d pulses expected 1", k, cfg_cnt);
      end
    end
    checks++;
    if (frame_cnt !== 11'(exp_fc)) begin
      failures++;
      $display("FAIL fade_in_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_hold_scroll();
    logic [1:0] exp_ph;
    logic [2:0] exp_bs;
    for (int k = 1; k <= 6; k++) begin
      run_frame(8);
      exp_fc++;
      exp_ph = (k < 4) ? 2'd1 : (k < 6) ? 2'd2 : 2'd3;
      exp_bs = (k == 4 || k == 5) ? 3'd3 : 3'd0;
      checks++;
      if (phase !== exp_ph || bg_step !== exp_bs || logo_rgb18 !== 18'h3FFFF) begin
        failures++;
        $display("FAIL hold_scroll_%0d: got phase=%0d bg_step=%0d logo=%h expected phase=%0d bg_step=%0d logo=3ffff",
                 k, phase, bg_step, logo_rgb18, exp_ph, exp_bs);
      end
    end
  endtask

  task automatic test_fade_out();
    logic [5:0] exp_lvl;
    for (int k = 1; k <= 8; k++) begin
      run_frame(8);
      exp_fc++;
      exp_lvl = (63 - 8 * k < 0) ? 6'd0 : 6'(63 - 8 * k);
      checks++;
      if (logo_rgb18 !== {3{exp_lvl}} || logo_en !== (k < 8) || phase !== ((k < 8) ? 2'd3 : 2'd0) ||
          bg_step !== 3'd0) begin
        failures++;
        $display("FAIL fade_out_%0d: got logo=%h en=%b phase=%0d bg_step=%0d expected logo=%h en=%b phase=%0d bg_step=0",
                 k, logo_rgb18, logo_en, phase, bg_step, {3{exp_lvl}}, k < 8, (k < 8) ? 3 : 0);
      end
    end
  endtask

  task automatic test_dir();
    for (int v = 0; v < 4; v++) clk1(10'(v));
    dir = 1'b1;
    for (int v = 4; v < 8; v++) clk1(10'(v));
    exp_fc++;
    checks++;
    if (bg_inc !== 18'h01FC1 || logo_rgb18 !== {3{6'd8}}) begin
      failures++;
      $display("FAIL dir_mid_frame: got bg_inc=%h logo=%h expected bg_inc=01fc1 logo=%h", bg_inc, logo_rgb18, {3{6'd8}});
    end
    run_frame(8);
    exp_fc++;
    checks++;
    if (bg_inc !== 18'h00FC1 || logo_rgb18 !== {3{6'd16}}) begin
      failures++;
      $display("FAIL dir_next_tick: got bg_inc=%h logo=%h expected bg_inc=00fc1 logo=%h", bg_inc, logo_rgb18, {3{6'd16}});
    end
    dir = 1'b0;
    run_frame(8);
    exp_fc++;
    checks++;
    if (bg_inc !== 18'h01FC1 || logo_rgb18 !== {3{6'd24}}) begin
      failures++;
      $display("FAIL dir_restore: got bg_inc=%h logo=%h expected bg_inc=01fc1 logo=%h", bg_inc, logo_rgb18, {3{6'd24}});
    end
  endtask

  task automatic test_pause();
`ifdef SCENE_PAUSE_EN
    pause   = 1'b1;
    cfg_cnt = 0;
    repeat (5) run_frame(8);
    exp_fc += 5;
    checks++;
    if (logo_rgb18 !== {3{6'd24}} || phase !== 2'd0 || cfg_cnt !== 0 || frame_cnt !== 11'(exp_fc)) begin
      failures++;
      $display("FAIL pause_frozen: got logo=%h phase=%0d cfg=%0d fc=%0d expected logo=%h phase=0 cfg=0 fc=%0d",
               logo_rgb18, phase, cfg_cnt, frame_cnt, {3{6'd24}}, exp_fc);
    end
    cfg_cnt = 0;
    step_frame();
    run_frame(8);
    exp_fc += 2;
    checks++;
    if (logo_rgb18 !== {3{6'd32}} || cfg_cnt !== 1) begin
      failures++;
      $display("FAIL step_single_advance: got logo=%h cfg=%0d expected logo=%h cfg=1", logo_rgb18, cfg_cnt, {3{6'd32}});
    end
    run_frame(8);
    exp_fc++;
    checks++;
    if (logo_rgb18 !== {3{6'd32}}) begin
      failures++;
      $display("FAIL step_disarmed: got logo=%h expected %h", logo_rgb18, {3{6'd32}});
    end
`else
    pause   = 1'b1;
    cfg_cnt = 0;
    step_frame();
    exp_fc++;
    checks++;
    if (logo_rgb18 !== {3{6'd32}} || cfg_cnt !== 1) begin
      failures++;
      $display("FAIL pause_ignored: got logo=%h cfg=%0d expected logo=%h cfg=1", logo_rgb18, cfg_cnt, {3{6'd32}});
    end
`endif
    pause = 1'b0;
    run_frame(8);
    exp_fc++;
    checks++;
    if (logo_rgb18 !== {3{6'd40}} || frame_cnt !== 11'(exp_fc)) begin
      failures++;
      $display("FAIL resume: got logo=%h fc=%0d expected logo=%h fc=%0d", logo_rgb18, frame_cnt, {3{6'd40}}, exp_fc);
    end
  endtask

  task automatic test_vpos_hold();
    cfg_cnt = 0;
    repeat (1000) clk1(10'd0);
    exp_fc++;
    checks++;
    if (cfg_cnt !== 1 || frame_cnt !== 11'(exp_fc) || logo_rgb18 !== {3{6'd48}}) begin
      failures++;
      $display("FAIL vpos_hold: got cfg=%0d fc=%0d logo=%h expected cfg=1 fc=%0d logo=%h",
               cfg_cnt, frame_cnt, logo_rgb18, exp_fc, {3{6'd48}});
    end
    run_frame(8);
  endtask

  task automatic test_wrap();
    while (exp_fc < 2047) begin
      run_frame(2);
      exp_fc++;
    end
    checks++;
    if (frame_cnt !== 11'd2047) begin
      failures++;
      $display("FAIL frame_cnt_max: got %0d expected 2047", frame_cnt);
    end
    run_frame(2);
    checks++;
    if (frame_cnt !== 11'd0) begin
      failures++;
      $display("FAIL frame_cnt_wrap: got %0d expected 0", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_scroll();
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    speed = 2'd1;
    run_frame(8);
    repeat (13) run_frame(8);
    checks++;
    if (phase !== 2'd2 || bg_step !== 3'd2 || logo_rgb18 !== 18'h3FFFF || frame_cnt !== 11'd13) begin
      failures++;
      $display("FAIL pre_reset_scroll: got phase=%0d bg_step=%0d logo=%h fc=%0d expected 2/2/3ffff/13",
               phase, bg_step, logo_rgb18, frame_cnt);
    end
    vpos = 10'd3;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_scroll");
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_hold_scroll();
    test_fade_out();
    test_dir();
    test_pause();
    test_vpos_hold();
    test_wrap();
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
